// File: rtl/dot_matrix_scan.sv
// -----------------------------------------------------------------------------
// dot_matrix_scan
//
// Row-scan driver for a 16x16 LED dot matrix. It walks a 4-bit row index out
// to an external combinational pattern ROM and samples the returned column
// word. It then lights that row with registered one-hot row and column drives.
// Each row slot lasts CLK_DIV cycles. The first BLANK_CYCLES cycles of a slot
// keep the matrix dark, so the ROM can settle on the new index and the
// previous row's data never ghosts onto the next row.
//
// Parameters
//   CLK_DIV      clock cycles per row slot, blanking included (> BLANK_CYCLES)
//   BLANK_CYCLES dark cycles at the start of each slot (>= 1)
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   scan enable, level-sensitive
//   col_in     in   [15:0] column word from the ROM for the current row_bin
//   row_bin    out  [3:0]  row index presented to the ROM
//   row        out  [15:0] one-hot row drive, active-high
//   col_out    out  [15:0] column drive, active-high
//   frame_done out  one-cycle pulse after the row-15 slot ends
// -----------------------------------------------------------------------------
module dot_matrix_scan #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [15:0] col_in,
  output logic [3:0]  row_bin,
  output logic [15:0] row,
  output logic [15:0] col_out,
  output logic        frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Terminal counts for the two timed states.
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(CLK_DIV - BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    row_bin_q, row_bin_d;
  logic [15:0]   row_q, row_d;
  logic [15:0]   col_q, col_d;   // column latch, driven straight to the pins
  logic          frame_q, frame_d;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      row_bin_q <= 4'd0;
      row_q     <= 16'd0;
      col_q     <= 16'd0;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_bin_q <= row_bin_d;
      row_q     <= row_d;
      col_q     <= col_d;
      frame_q   <= frame_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_bin_d = row_bin_q;
    row_d     = row_q;
    col_d     = col_q;
    frame_d   = 1'b0;   // pulse: only asserted on the wrap edge

    case (state_q)
      S_IDLE: begin
        row_bin_d = 4'd0;
        row_d     = 16'd0;
        col_d     = 16'd0;
        cnt_d     = '0;
        if (en) begin
          state_d = S_BLANK;
        end
      end

      S_BLANK: begin
        if (!en) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          row_bin_d = 4'd0;
          row_d     = 16'd0;
          col_d     = 16'd0;
        end else if (cnt_q == BLANK_LAST) begin
          // Row select and column data switch on together, so a lit row
          // never carries the previous row's columns.
          col_d   = col_in;
          row_d   = 16'd1 << row_bin_q;
          state_d = S_SHOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_SHOW: begin
        if (!en) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          row_bin_d = 4'd0;
          row_d     = 16'd0;
          col_d     = 16'd0;
        end else if (cnt_q == SHOW_LAST) begin
          // Go dark and advance the ROM address on the same edge; the ROM
          // then has the whole blanking interval to settle.
          row_d     = 16'd0;
          col_d     = 16'd0;
          row_bin_d = row_bin_q + 4'd1;
          frame_d   = (row_bin_q == 4'd15);
          state_d   = S_BLANK;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d   = S_IDLE;
        cnt_d     = '0;
        row_bin_d = 4'd0;
        row_d     = 16'd0;
        col_d     = 16'd0;
      end
    endcase
  end

  assign row_bin    = row_bin_q;
  assign row        = row_q;
  assign col_out    = col_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_dot_matrix_scan.sv
// -----------------------------------------------------------------------------
// tb_dot_matrix_scan
//
// Bench for dot_matrix_scan with CLK_DIV=8, BLANK_CYCLES=2. A pattern ROM
// model feeds col_in from row_bin (with an optional override). A reference
// model tracks the scan as "cycles since the scan started" and derives every
// expected output from slot/phase arithmetic on that count. Each test task
// drives its own scenario and compares outputs every cycle.
// -----------------------------------------------------------------------------
module tb_dot_matrix_scan;

  localparam int CLK_DIV = 8;
  localparam int BLANK   = 2;
  localparam int SHOW    = CLK_DIV - BLANK;
  localparam int FRAME   = 16 * CLK_DIV;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [15:0] col_in;
  logic [3:0]  row_bin;
  logic [15:0] row;
  logic [15:0] col_out;
  logic        frame_done;

  logic        force_en  = 1'b0;
  logic [15:0] force_val = 16'hFFFF;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [3:0] r);
    case (r)
      4'd1, 4'd7, 4'd13:  return 16'h0FF0;
      4'd0, 4'd14, 4'd15: return 16'h0000;
      default:            return 16'h0010;
    endcase
  endfunction

  assign col_in = force_en ? force_val : rom(row_bin);

  dot_matrix_scan #(
    .CLK_DIV     (CLK_DIV),
    .BLANK_CYCLES(BLANK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .col_in    (col_in),
    .row_bin   (row_bin),
    .row       (row),
    .col_out   (col_out),
    .frame_done(frame_done)
  );

  logic [36:0] dut_vec;
  assign dut_vec = {row_bin, row, col_out, frame_done};

  // ---------------------------------------------------------------------------
  // Reference model: scan active flag, cycles since scan start, sampled column.
  // ---------------------------------------------------------------------------
  logic        m_active = 1'b0;
  int          m_t      = 0;
  logic [15:0] m_col    = 16'h0000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else if (!m_active) begin
      if (en) begin
        m_active <= 1'b1;
        m_t      <= 0;
      end
    end else if (!en) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else begin
      m_t <= m_t + 1;
      if ((m_t % CLK_DIV) == BLANK - 1) m_col <= col_in;
    end
  end

  function automatic int m_phase();
    return m_t % CLK_DIV;
  endfunction

  function automatic int m_row();
    return (m_t / CLK_DIV) % 16;
  endfunction

  function automatic logic [36:0] exp_vec();
    int          ph;
    int          sl;
    logic [3:0]  rb;
    logic [15:0] r;
    logic [15:0] c;
    logic        fd;
    if (!m_active) return '0;
    ph = m_t % CLK_DIV;
    sl = m_t / CLK_DIV;
    rb = 4'(sl % 16);
    r  = (ph >= BLANK) ? (16'h0001 << rb) : 16'h0000;
    c  = (ph >= BLANK) ? m_col : 16'h0000;
    fd = (ph == 0) && (sl > 0) && (rb == 4'd0);
    return {rb, r, c, fd};
  endfunction

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== 37'd0) begin
        miscompares++;
        $display("FAIL reset_hold got %h want %h", dut_vec, 37'd0);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);   // first edge samples en=1 in IDLE
    vectors++;
    if (row_bin !== 4'd0 || row !== 16'd0 || col_out !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_first_dark got rb=%h row=%h col=%h want 0/0/0", row_bin, row, col_out);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_model got %h want %h", dut_vec, exp_vec());
      end
    end
    vectors++;
    if (row !== 16'h0001 || col_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_row0 got row=%h col=%h want 0001/0000", row, col_out);
    end
  endtask

  task automatic test_row_sequence();
    int guard = 0;
    while (!(m_active && m_row() == 1 && m_phase() == BLANK) && guard < 300) begin
      @(negedge clk);
      guard++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL rowseq_model got %h want %h", dut_vec, exp_vec());
      end
    end
    vectors++;
    if (guard >= 300) begin
      miscompares++;
      $display("FAIL rowseq_timeout got %0d cycles want <300", guard);
    end
    for (int i = 0; i < SHOW; i++) begin
      vectors++;
      if (row !== 16'h0002 || col_out !== 16'h0FF0) begin
        miscompares++;
        $display("FAIL rowseq_row1 cyc=%0d got row=%h col=%h want 0002/0FF0", i, row, col_out);
      end
      @(negedge clk);
    end
    for (int i = 0; i < BLANK; i++) begin
      vectors++;
      if (row !== 16'h0000 || col_out !== 16'h0000 || row_bin !== 4'd2) begin
        miscompares++;
        $display("FAIL rowseq_blank cyc=%0d got rb=%h row=%h col=%h want 2/0000/0000", i, row_bin, row, col_out);
      end
      @(negedge clk);
    end
    vectors++;
    if (row !== 16'h0004 || col_out !== 16'h0010) begin
      miscompares++;
      $display("FAIL rowseq_row2 got row=%h col=%h want 0004/0010", row, col_out);
    end
  endtask

  task automatic test_wrap_frame();
    int guard = 0;
    int gap   = 0;
    while (frame_done !== 1'b1 && guard < FRAME + 20) begin
      @(negedge clk);
      guard++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap_model got %h want %h", dut_vec, exp_vec());
      end
    end
    vectors++;
    if (frame_done !== 1'b1 || row_bin !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap_first_pulse got fd=%b rb=%h want 1/0", frame_done, row_bin);
    end
    @(negedge clk);
    vectors++;
    if (frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_pulse_width got %b want 0", frame_done);
    end
    gap = 1;
    while (frame_done !== 1'b1 && gap < FRAME + 20) begin
      @(negedge clk);
      gap++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL wrap_model2 got %h want %h", dut_vec, exp_vec());
      end
    end
    vectors++;
    if (gap != FRAME) begin
      miscompares++;
      $display("FAIL wrap_period got %0d want %0d", gap, FRAME);
    end
  endtask

  task automatic test_sample_window();
    int guard = 0;
    while (!(m_active && m_row() == 3 && m_phase() == BLANK + 1) && guard < 300) begin
      @(negedge clk);
      guard++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL sample_model got %h want %h", dut_vec, exp_vec());
      end
    end
    force_val = 16'hFFFF;
    force_en  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if (col_out !== 16'h0010 || row !== 16'h0008) begin
        miscompares++;
        $display("FAIL sample_show_ignored got row=%h col=%h want 0008/0010", row, col_out);
      end
    end
    force_en = 1'b0;
    guard = 0;
    while (!(m_active && m_row() == 4 && m_phase() == BLANK - 1) && guard < 300) begin
      @(negedge clk);
      guard++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL sample_model2 got %h want %h", dut_vec, exp_vec());
      end
    end
    force_en = 1'b1;
    @(negedge clk);
    force_en = 1'b0;
    for (int i = 0; i < SHOW; i++) begin
      vectors++;
      if (col_out !== 16'hFFFF || row !== 16'h0010) begin
        miscompares++;
        $display("FAIL sample_latched cyc=%0d got row=%h col=%h want 0010/FFFF", i, row, col_out);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_disable();
    int guard = 0;
    while (!(m_active && m_row() == 5 && m_phase() == BLANK + 2) && guard < 300) begin
      @(negedge clk);
      guard++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL disable_model got %h want %h", dut_vec, exp_vec());
      end
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== 37'd0) begin
        miscompares++;
        $display("FAIL disable_idle cyc=%0d got %h want %h", i, dut_vec, 37'd0);
      end
    end
    en = 1'b1;
    @(negedge clk);
    vectors++;
    if (row_bin !== 4'd0 || row !== 16'd0) begin
      miscompares++;
      $display("FAIL disable_restart_dark got rb=%h row=%h want 0/0000", row_bin, row);
    end
    repeat (BLANK) @(negedge clk);
    vectors++;
    if (row !== 16'h0001 || col_out !== 16'h0000) begin
      miscompares++;
      $display("FAIL disable_restart_row0 got row=%h col=%h want 0001/0000", row, col_out);
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    while (!(m_active && m_row() == 9 && m_phase() == BLANK + 1) && guard < 300) begin
      @(negedge clk);
      guard++;
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL areset_model got %h want %h", dut_vec, exp_vec());
      end
    end
    vectors++;
    if (row !== 16'h0200) begin
      miscompares++;
      $display("FAIL areset_pre got row=%h want 0200", row);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (dut_vec !== 37'd0) begin
      miscompares++;
      $display("FAIL areset_immediate got %h want %h", dut_vec, 37'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < CLK_DIV + 4; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL areset_restart got %h want %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      vectors++;
      if (dut_vec !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_model cyc=%0d got %h want %h", i, dut_vec, exp_vec());
      end
      en        = ($urandom_range(0, 79) != 0);
      force_en  = ($urandom_range(0, 3) == 0);
      force_val = 16'($urandom);
    end
    force_en = 1'b0;
    en       = 1'b1;
  endtask

  initial begin
    test_reset();
    test_row_sequence();
    test_wrap_frame();
    test_sample_window();
    test_disable();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
